// File: rtl/ps2_key_decoder_if.sv
// Keyboard-side signal bundle between the PS/2 front end and the Apple I/O block.
// The master drives the raw PS/2 pins and the strobe clear.
// The slave, which is the decoder, returns the keyboard latch and the held-key levels.
interface ps2_key_decoder_if;
  logic       PS2Clk;
  logic       PS2Din;
  logic       clearData;
  logic [7:0] ascii;
  logic       keyState;
  logic [9:0] specialKey;

  modport master (
    output PS2Clk, PS2Din, clearData,
    input  ascii, keyState, specialKey
  );

  modport slave (
    input  PS2Clk, PS2Din, clearData,
    output ascii, keyState, specialKey
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: input conditioning, frame receiver, scan-code set 2
// decoder and Apple II keyboard latch.
//
// Decoder FSM states:
//   state  | meaning
//   IDLE   | waiting for a make code or a prefix
//   EXT    | E0 seen, next code is an extended make
//   BRK    | F0 seen, next code is a break
//   EXTBRK | E0 F0 seen, next code is an extended break
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic            clk,
  input logic            cpuRstN,
  ps2_key_decoder_if.slave kbd
);

  localparam int FLT_W  = $clog2(FILTER_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXT    = 2'd1;
  localparam logic [1:0] BRK    = 2'd2;
  localparam logic [1:0] EXTBRK = 2'd3;

  logic [1:0]        rstSync;
  logic              rstN;
  logic [1:0]        clkSync;
  logic [1:0]        dinSync;
  logic [1:0]        clrSync;
  logic              clrSyncD;
  logic              clrRise;
  logic              filtClk;
  logic [FLT_W-1:0]  fltCnt;
  logic              fallNow;
  logic [10:0]       shiftReg;
  logic [10:0]       frameNext;
  logic              frameOk;
  logic [3:0]        bitCnt;
  logic [IDLE_W-1:0] idleCnt;
  logic              byteValid;
  logic [7:0]        rxByte;
  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic              doMake;
  logic              doBreak;
  logic              keyExt;
  logic [8:0]        keyId;
  logic [7:0]        xlat;
  logic [8:0]        lastCode;
  logic [7:0]        asciiReg;
  logic              keyStateReg;
  logic              lShift, rShift, lCtrl, rCtrl, delHeld;
  logic              f6Held, f10Held, kp4Held, kp6Held, kp8Held, kp2Held;
  logic              kpMinusHeld, kpStarHeld, kpSlashHeld;
  logic              shiftHeld, ctrlHeld;

  // Returns {translatable, apple ascii}; bit 7 doubles as the strobe value.
  function automatic logic [7:0] translate(input logic [7:0] code, input logic ext,
                                           input logic shift, input logic ctrl);
    logic [6:0] letter;
    logic [7:0] res;
    res    = 8'h00;
    letter = 7'h00;
    if (ext) begin
      case (code)
        8'h6B:   res = 8'h88;
        8'h74:   res = 8'h95;
        default: res = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1C: letter = 7'h41;  8'h32: letter = 7'h42;  8'h21: letter = 7'h43;
        8'h23: letter = 7'h44;  8'h24: letter = 7'h45;  8'h2B: letter = 7'h46;
        8'h34: letter = 7'h47;  8'h33: letter = 7'h48;  8'h43: letter = 7'h49;
        8'h3B: letter = 7'h4A;  8'h42: letter = 7'h4B;  8'h4B: letter = 7'h4C;
        8'h3A: letter = 7'h4D;  8'h31: letter = 7'h4E;  8'h44: letter = 7'h4F;
        8'h4D: letter = 7'h50;  8'h15: letter = 7'h51;  8'h2D: letter = 7'h52;
        8'h1B: letter = 7'h53;  8'h2C: letter = 7'h54;  8'h3C: letter = 7'h55;
        8'h2A: letter = 7'h56;  8'h1D: letter = 7'h57;  8'h22: letter = 7'h58;
        8'h35: letter = 7'h59;  8'h1A: letter = 7'h5A;
        default: letter = 7'h00;
      endcase
      if (letter != 7'h00) begin
        res = {1'b1, ctrl ? (letter - 7'h40) : letter};
      end else begin
        case (code)
          8'h16:   res = shift ? 8'hA1 : 8'hB1;
          8'h1E:   res = shift ? 8'hC0 : 8'hB2;
          8'h26:   res = shift ? 8'hA3 : 8'hB3;
          8'h25:   res = shift ? 8'hA4 : 8'hB4;
          8'h2E:   res = shift ? 8'hA5 : 8'hB5;
          8'h36:   res = shift ? 8'hDE : 8'hB6;
          8'h3D:   res = shift ? 8'hA6 : 8'hB7;
          8'h3E:   res = shift ? 8'hAA : 8'hB8;
          8'h46:   res = shift ? 8'hA8 : 8'hB9;
          8'h45:   res = shift ? 8'hA9 : 8'hB0;
          8'h29:   res = 8'hA0;
          8'h5A:   res = 8'h8D;
          8'h76:   res = 8'h9B;
          8'h66:   res = 8'h88;
          default: res = 8'h00;
        endcase
      end
    end
    return res;
  endfunction

  // Reset synchronizer: assert immediately, release two clocks later.
  always_ff @(posedge clk or negedge cpuRstN) begin
    if (!cpuRstN) rstSync <= 2'b00;
    else          rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  // Two-flop synchronizers for the asynchronous pins plus clear edge history.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      clkSync  <= 2'b11;
      dinSync  <= 2'b11;
      clrSync  <= 2'b00;
      clrSyncD <= 1'b0;
    end else begin
      clkSync  <= {clkSync[0], kbd.PS2Clk};
      dinSync  <= {dinSync[0], kbd.PS2Din};
      clrSync  <= {clrSync[0], kbd.clearData};
      clrSyncD <= clrSync[1];
    end
  end
  assign clrRise = clrSync[1] & ~clrSyncD;

  // The glitch filter down-counts while the synced clock differs from the filtered level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      filtClk <= 1'b1;
      fltCnt  <= FLT_W'(FILTER_LEN - 1);
    end else if (clkSync[1] == filtClk) begin
      fltCnt <= FLT_W'(FILTER_LEN - 1);
    end else if (fltCnt == '0) begin
      filtClk <= clkSync[1];
      fltCnt  <= FLT_W'(FILTER_LEN - 1);
    end else begin
      fltCnt <= fltCnt - 1'b1;
    end
  end

  // High in the cycle that ends with the filtered clock falling.
  assign fallNow   = filtClk && !clkSync[1] && (fltCnt == '0);
  assign frameNext = {dinSync[1], shiftReg[10:1]};
  assign frameOk   = !frameNext[0] && (^frameNext[9:1]) && frameNext[10];

  // Frame receiver: shift in on falling edges, check at bit 10, drop stale partial frames.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shiftReg  <= '0;
      bitCnt    <= 4'd0;
      idleCnt   <= IDLE_W'(TIMEOUT_CYC);
      byteValid <= 1'b0;
      rxByte    <= 8'h00;
    end else begin
      byteValid <= 1'b0;
      if (fallNow) begin
        shiftReg <= frameNext;
        idleCnt  <= IDLE_W'(TIMEOUT_CYC);
        if (bitCnt == 4'd10) begin
          bitCnt <= 4'd0;
          if (frameOk) begin
            byteValid <= 1'b1;
            rxByte    <= frameNext[8:1];
          end
        end else begin
          bitCnt <= bitCnt + 4'd1;
        end
      end else if (bitCnt != 4'd0) begin
        if (idleCnt == '0) bitCnt <= 4'd0;
        else               idleCnt <= idleCnt - 1'b1;
      end else begin
        idleCnt <= IDLE_W'(TIMEOUT_CYC);
      end
    end
  end

  // Prefix tracking: classify each received byte as prefix, make or break.
  always_comb begin
    stateNext = state;
    doMake    = 1'b0;
    doBreak   = 1'b0;
    keyExt    = 1'b0;
    if (byteValid) begin
      case (state)
        IDLE: begin
          if (rxByte == 8'hE0)      stateNext = EXT;
          else if (rxByte == 8'hF0) stateNext = BRK;
          else                      doMake = 1'b1;
        end
        EXT: begin
          if (rxByte == 8'hE0)      stateNext = EXT;
          else if (rxByte == 8'hF0) stateNext = EXTBRK;
          else begin
            doMake    = 1'b1;
            keyExt    = 1'b1;
            stateNext = IDLE;
          end
        end
        BRK: begin
          doBreak   = 1'b1;
          stateNext = IDLE;
        end
        default: begin
          doBreak   = 1'b1;
          keyExt    = 1'b1;
          stateNext = IDLE;
        end
      endcase
    end
  end

  assign keyId     = {keyExt, rxByte};
  assign shiftHeld = lShift | rShift;
  assign ctrlHeld  = lCtrl | rCtrl;
  assign xlat      = translate(rxByte, keyExt, shiftHeld, ctrlHeld);

  // Decoder state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  // Modifier and held-key flags: set on make, clear on break of the same key.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      {lShift, rShift, lCtrl, rCtrl, delHeld} <= 5'b0;
      {f6Held, f10Held, kp4Held, kp6Held, kp8Held, kp2Held} <= 6'b0;
      {kpMinusHeld, kpStarHeld, kpSlashHeld} <= 3'b0;
    end else if (doMake || doBreak) begin
      case (keyId)
        9'h012:  lShift      <= doMake;
        9'h059:  rShift      <= doMake;
        9'h014:  lCtrl       <= doMake;
        9'h114:  rCtrl       <= doMake;
        9'h171:  delHeld     <= doMake;
        9'h00B:  f6Held      <= doMake;
        9'h009:  f10Held     <= doMake;
        9'h06B:  kp4Held     <= doMake;
        9'h074:  kp6Held     <= doMake;
        9'h075:  kp8Held     <= doMake;
        9'h072:  kp2Held     <= doMake;
        9'h07B:  kpMinusHeld <= doMake;
        9'h07C:  kpStarHeld  <= doMake;
        9'h14A:  kpSlashHeld <= doMake;
        default: ;
      endcase
    end
  end

  // Keyboard latch. A translatable make outranks a simultaneous strobe clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      asciiReg    <= 8'h00;
      keyStateReg <= 1'b0;
      lastCode    <= 9'h000;
    end else begin
      if (doMake && xlat[7]) begin
        asciiReg    <= xlat;
        keyStateReg <= 1'b1;
        lastCode    <= keyId;
      end else begin
        if (clrRise) asciiReg[7] <= 1'b0;
        if (doBreak && keyId == lastCode) keyStateReg <= 1'b0;
      end
    end
  end

  assign kbd.ascii      = asciiReg;
  assign kbd.keyState   = keyStateReg;
  assign kbd.specialKey = {kpSlashHeld, kpStarHeld, kpMinusHeld, kp2Held, kp8Held,
                           kp6Held, kp4Held, f10Held, f6Held,
                           ctrlHeld & shiftHeld & delHeld};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: serial PS/2 frames in, latch outputs checked.
module tb_ps2_key_decoder;
  localparam int HALF = 20;
  localparam int TO   = 2000;

  logic clk = 1'b0;
  logic cpuRstN = 1'b0;
  int   errCnt = 0;
  int   chkCnt = 0;

  ps2_key_decoder_if kbd();

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .cpuRstN(cpuRstN),
    .kbd(kbd.slave)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sends nBits of one frame; optionally raises clearData so its synced edge
  // lands in the same cycle as byteValid of this frame.
  task automatic sendFrame(input logic [7:0] data, input logic badPar, input int nBits,
                           input logic clrAtEnd);
    logic [10:0] f;
    f = {1'b1, (~^data) ^ badPar, data, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk) kbd.PS2Din = f[i];
      repeat (HALF) @(negedge clk);
      kbd.PS2Clk = 1'b0;
      if (clrAtEnd && i == 10) begin
        repeat (8) @(negedge clk);
        kbd.clearData = 1'b1;
        repeat (HALF - 8) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      kbd.PS2Clk = 1'b1;
    end
    repeat (30) @(negedge clk);
    kbd.PS2Din = 1'b1;
  endtask

  task automatic key(input logic [7:0] data);
    sendFrame(data, 1'b0, 11, 1'b0);
  endtask

  task automatic clearPulse();
    @(negedge clk) kbd.clearData = 1'b1;
    repeat (5) @(negedge clk);
    kbd.clearData = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    kbd.PS2Clk    = 1'b1;
    kbd.PS2Din    = 1'b1;
    kbd.clearData = 1'b0;
    repeat (5) @(negedge clk);
    checkVal("rst_ascii", {8'h00, kbd.ascii}, 16'h0000);
    checkVal("rst_keyState", {15'h0, kbd.keyState}, 16'h0000);
    checkVal("rst_special", {6'h0, kbd.specialKey}, 16'h0000);
    cpuRstN = 1'b1;
    repeat (10) @(negedge clk);

    key(8'h1C);
    checkVal("a_make_ascii", {8'h00, kbd.ascii}, 16'h00C1);
    checkVal("a_make_keyState", {15'h0, kbd.keyState}, 16'h0001);
    key(8'hF0); key(8'h1C);
    checkVal("a_break_keyState", {15'h0, kbd.keyState}, 16'h0000);
    checkVal("a_break_ascii", {8'h00, kbd.ascii}, 16'h00C1);
    clearPulse();
    checkVal("clear_ascii", {8'h00, kbd.ascii}, 16'h0041);

    sendFrame(8'h1C, 1'b1, 11, 1'b0);
    checkVal("badpar_ascii", {8'h00, kbd.ascii}, 16'h0041);
    checkVal("badpar_keyState", {15'h0, kbd.keyState}, 16'h0000);
    key(8'h32);
    checkVal("b_make_ascii", {8'h00, kbd.ascii}, 16'h00C2);

    key(8'h14); key(8'h12); key(8'hE0); key(8'h71);
    checkVal("csd_set", {6'h0, kbd.specialKey}, 16'h0001);
    checkVal("csd_ascii", {8'h00, kbd.ascii}, 16'h00C2);
    key(8'h1C);
    checkVal("ctrl_a_ascii", {8'h00, kbd.ascii}, 16'h0081);
    key(8'hE0); key(8'hF0); key(8'h71);
    checkVal("csd_clr", {6'h0, kbd.specialKey}, 16'h0000);
    key(8'hF0); key(8'h14); key(8'hF0); key(8'h12);

    sendFrame(8'h55, 1'b0, 5, 1'b0);
    repeat (TO + 10) @(negedge clk);
    key(8'h16);
    checkVal("timeout_digit1", {8'h00, kbd.ascii}, 16'h00B1);
    key(8'h12); key(8'h16);
    checkVal("shift_bang", {8'h00, kbd.ascii}, 16'h00A1);
    key(8'hF0); key(8'h12);
    key(8'h5A);
    checkVal("enter_ascii", {8'h00, kbd.ascii}, 16'h008D);

    key(8'h0B);
    checkVal("f6_special", {6'h0, kbd.specialKey}, 16'h0002);
    checkVal("f6_ascii", {8'h00, kbd.ascii}, 16'h008D);
    key(8'hE0); key(8'h6B);
    checkVal("left_ascii", {8'h00, kbd.ascii}, 16'h0088);
    checkVal("left_no_kp4", {6'h0, kbd.specialKey}, 16'h0002);
    key(8'hF0); key(8'h0B);
    key(8'h6B);
    checkVal("kp4_special", {6'h0, kbd.specialKey}, 16'h0008);
    checkVal("kp4_ascii", {8'h00, kbd.ascii}, 16'h0088);
    key(8'hF0); key(8'h6B);
    checkVal("kp4_break_special", {6'h0, kbd.specialKey}, 16'h0000);
    checkVal("kp4_break_keyState", {15'h0, kbd.keyState}, 16'h0001);

    sendFrame(8'h29, 1'b0, 11, 1'b1);
    checkVal("space_vs_clear", {8'h00, kbd.ascii}, 16'h00A0);
    key(8'h1C);
    checkVal("clear_held_no_reclear", {8'h00, kbd.ascii}, 16'h00C1);
    kbd.clearData = 1'b0;
    repeat (10) @(negedge clk);
    clearPulse();
    checkVal("clear_again", {8'h00, kbd.ascii}, 16'h0041);

    key(8'h0B);
    sendFrame(8'h32, 1'b0, 5, 1'b0);
    cpuRstN = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("midrst_ascii", {8'h00, kbd.ascii}, 16'h0000);
    checkVal("midrst_keyState", {15'h0, kbd.keyState}, 16'h0000);
    checkVal("midrst_special", {6'h0, kbd.specialKey}, 16'h0000);
    cpuRstN = 1'b1;
    repeat (10) @(negedge clk);
    key(8'h32);
    checkVal("post_rst_ascii", {8'h00, kbd.ascii}, 16'h00C2);
    checkVal("post_rst_keyState", {15'h0, kbd.keyState}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
